// File: rtl/okv_solver.sv
// Wolf/sheep/cabbage ferry sequencer: issues the seven fixed moves, waits SETTLE
// cycles after each strobe, then checks the observed bank state before continuing.
module okv_solver #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] state_in,
    output logic       wolf,
    output logic       sheep,
    output logic       cab,
    output logic       move,
    output logic [2:0] step,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       unsafe
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE, ERR} state_t;

    state_t     st;
    logic [3:0] cnt;

    // {wolf, sheep, cab} carried on each move; 000 means the farmer crosses alone
    function automatic logic [2:0] cargo(input logic [2:0] s);
        case (s)
            3'd0, 3'd3, 3'd6: cargo = 3'b010;
            3'd2:             cargo = 3'b100;
            3'd4:             cargo = 3'b001;
            default:          cargo = 3'b000;
        endcase
    endfunction

    // bank state {farmer, wolf, sheep, cab} that must be observed after each move
    function automatic logic [3:0] expect_state(input logic [2:0] s);
        case (s)
            3'd0:    expect_state = 4'b1010;
            3'd1:    expect_state = 4'b0010;
            3'd2:    expect_state = 4'b1110;
            3'd3:    expect_state = 4'b0100;
            3'd4:    expect_state = 4'b1101;
            3'd5:    expect_state = 4'b0101;
            default: expect_state = 4'b1111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= IDLE;
            cnt    <= 4'd0;
            step   <= 3'd0;
            move   <= 1'b0;
            wolf   <= 1'b0;
            sheep  <= 1'b0;
            cab    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            unsafe <= 1'b0;
        end else begin
            move               <= 1'b0;
            {wolf, sheep, cab} <= 3'b000;
            unsafe <= ((state_in[2] == state_in[1]) && (state_in[3] != state_in[1])) ||
                      ((state_in[1] == state_in[0]) && (state_in[3] != state_in[1]));
            case (st)
                IDLE: begin
                    if (start) begin
                        if (state_in == 4'b0000) begin
                            st                 <= ISSUE;
                            step               <= 3'd0;
                            busy               <= 1'b1;
                            move               <= 1'b1;
                            {wolf, sheep, cab} <= cargo(3'd0);
                        end else begin
                            st  <= ERR;
                            err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    st  <= WAIT;
                    cnt <= 4'(SETTLE - 1);
                end
                WAIT: begin
                    if (cnt == 4'd0) st <= CHECK;
                    else             cnt <= cnt - 4'd1;
                end
                CHECK: begin
                    if (state_in != expect_state(step)) begin
                        st   <= ERR;
                        busy <= 1'b0;
                        err  <= 1'b1;
                    end else if (step == 3'd6) begin
                        st   <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        st                 <= ISSUE;
                        step               <= step + 3'd1;
                        move               <= 1'b1;
                        {wolf, sheep, cab} <= cargo(step + 3'd1);
                    end
                end
                DONE, ERR: ;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_okv_solver.sv
// Directed bench for okv_solver: two instances (SETTLE=1 and SETTLE=4) share the
// inputs; sel picks which one's outputs are observed.
module tb_okv_solver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] state_in = 4'b0000;
    logic       sel = 1'b0;

    logic       wolf_a, sheep_a, cab_a, move_a, busy_a, done_a, err_a, unsafe_a;
    logic       wolf_b, sheep_b, cab_b, move_b, busy_b, done_b, err_b, unsafe_b;
    logic [2:0] step_a, step_b;

    logic       wolf, sheep, cab, move, busy, done, err, unsafe;
    logic [2:0] step;

    okv_solver #(.SETTLE(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .wolf(wolf_a), .sheep(sheep_a), .cab(cab_a), .move(move_a), .step(step_a),
        .busy(busy_a), .done(done_a), .err(err_a), .unsafe(unsafe_a)
    );

    okv_solver #(.SETTLE(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .wolf(wolf_b), .sheep(sheep_b), .cab(cab_b), .move(move_b), .step(step_b),
        .busy(busy_b), .done(done_b), .err(err_b), .unsafe(unsafe_b)
    );

    assign wolf   = sel ? wolf_b   : wolf_a;
    assign sheep  = sel ? sheep_b  : sheep_a;
    assign cab    = sel ? cab_b    : cab_a;
    assign move   = sel ? move_b   : move_a;
    assign step   = sel ? step_b   : step_a;
    assign busy   = sel ? busy_b   : busy_a;
    assign done   = sel ? done_b   : done_a;
    assign err    = sel ? err_b    : err_a;
    assign unsafe = sel ? unsafe_b : unsafe_a;

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] exp_state [7] = '{4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b1111};
    logic [2:0] exp_wsc   [7] = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};

    int         n_str, done_cyc, err_cyc, excl_bad;
    int         str_cyc  [8];
    logic [2:0] str_wsc  [8];
    logic [2:0] str_step [8];

    // Bank model: pulses start, then after each strobe applies the resulting bank
    // state one cycle later (only for moves below upd_lim). cyc 0 = first negedge
    // after the edge that samples start.
    task automatic run_seq(input int ncyc, input int upd_lim, input int restart_at);
        logic [3:0] pend;
        logic       pend_vld;
        pend = 4'b0000; pend_vld = 1'b0;
        n_str = 0; done_cyc = -1; err_cyc = -1; excl_bad = 0;
        state_in = 4'b0000;
        start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (pend_vld) begin
                state_in = pend;
                pend_vld = 1'b0;
            end
            if (move) begin
                if (n_str < 8) begin
                    str_cyc[n_str]  = c;
                    str_wsc[n_str]  = {wolf, sheep, cab};
                    str_step[n_str] = step;
                end
                if (int'(step) < upd_lim) begin
                    pend = exp_state[step];
                    pend_vld = 1'b1;
                end
                n_str++;
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (err && err_cyc < 0) err_cyc = c;
            if (int'(busy) + int'(done) + int'(err) > 1) excl_bad++;
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        state_in = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({wolf, sheep, cab, move, step, busy, done, err, unsafe} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_held: outputs=%b expected all 0", {wolf, sheep, cab, move, step, busy, done, err, unsafe});
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        vectors++;
        if ({move, step, busy, done, err, unsafe} !== 8'd0) begin
            miscompares++;
            $display("FAIL idle_no_start: outputs=%b expected all 0", {move, step, busy, done, err, unsafe});
        end
    endtask

    task automatic test_full_sequence(input logic use_b, input int spacing, input int restart_at);
        sel = use_b;
        run_seq(spacing * 7 + 8, 7, restart_at);
        vectors++;
        if (n_str != 7) begin
            miscompares++;
            $display("FAIL strobe_count(sel=%0d): got %0d expected 7", use_b, n_str);
        end
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if (str_wsc[k] !== exp_wsc[k] || str_step[k] !== 3'(k) || str_cyc[k] != spacing * k) begin
                miscompares++;
                $display("FAIL strobe%0d(sel=%0d): wsc=%b step=%0d cyc=%0d expected wsc=%b step=%0d cyc=%0d",
                         k, use_b, str_wsc[k], str_step[k], str_cyc[k], exp_wsc[k], k, spacing * k);
            end
        end
        vectors++;
        if (done_cyc != spacing * 7 || step !== 3'd6 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done(sel=%0d): done_cyc=%0d step=%0d done=%b busy=%b expected %0d 6 1 0",
                     use_b, done_cyc, step, done, busy, spacing * 7);
        end
        vectors++;
        if (excl_bad != 0 || err_cyc != -1) begin
            miscompares++;
            $display("FAIL exclusive(sel=%0d): overlaps=%0d err_cyc=%0d expected 0 -1", use_b, excl_bad, err_cyc);
        end
        // DONE is terminal: another start must do nothing
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || move !== 1'b0 || step !== 3'd6) begin
            miscompares++;
            $display("FAIL done_terminal(sel=%0d): done=%b move=%b step=%0d expected 1 0 6", use_b, done, move, step);
        end
    endtask

    task automatic test_start_err();
        sel = 1'b0;
        state_in = 4'b0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (err !== 1'b1 || move !== 1'b0 || busy !== 1'b0 || step !== 3'd0) begin
            miscompares++;
            $display("FAIL start_err: err=%b move=%b busy=%b step=%0d expected 1 0 0 0", err, move, busy, step);
        end
        state_in = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || move !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL err_terminal: err=%b move=%b done=%b expected 1 0 0", err, move, done);
        end
    endtask

    task automatic test_mismatch();
        sel = 1'b0;
        run_seq(25, 1, -1);
        vectors++;
        if (n_str != 2 || err_cyc != 6) begin
            miscompares++;
            $display("FAIL mismatch_flow: strobes=%0d err_cyc=%0d expected 2 6", n_str, err_cyc);
        end
        vectors++;
        if (err !== 1'b1 || step !== 3'd1 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mismatch_state: err=%b step=%0d done=%b busy=%b expected 1 1 0 0", err, step, done, busy);
        end
    endtask

    task automatic test_async_reset();
        sel = 1'b0;
        run_seq(11, 7, -1);
        vectors++;
        if (step !== 3'd3 || busy !== 1'b1 || move !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset: step=%0d busy=%b move=%b expected 3 1 0", step, busy, move);
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({wolf, sheep, cab, move, step, busy, done, err, unsafe} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset: outputs=%b expected all 0", {wolf, sheep, cab, move, step, busy, done, err, unsafe});
        end
        @(negedge clk);
        rst = 1'b1;
        state_in = 4'b0000;
        n_str = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (move || busy) n_str++;
        end
        vectors++;
        if (n_str != 0 || step !== 3'd0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: active=%0d step=%0d done=%b err=%b expected 0 0 0 0", n_str, step, done, err);
        end
    endtask

    task automatic test_unsafe();
        logic [3:0] pat [5] = '{4'b0110, 4'b1110, 4'b0011, 4'b1001, 4'b0000};
        logic       exp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            state_in = pat[i];
            @(negedge clk);
            vectors++;
            if (unsafe !== exp[i] || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL unsafe_%b: unsafe=%b busy=%b expected %b 0", pat[i], unsafe, busy, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence(1'b0, 3, -1);
        do_reset();
        test_start_err();
        do_reset();
        test_mismatch();
        do_reset();
        test_async_reset();
        do_reset();
        test_unsafe();
        do_reset();
        test_full_sequence(1'b1, 6, 10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
